// File: rtl/add_header_post_if.sv
// Stream bundle for add_header_post: data in, packet-length in, framed data out, status.
// slave = the header-insert block, master = the upstream/downstream environment.
interface add_header_post_if #(
    parameter int DW = 128
);
    logic [DW-1:0]   axis_in_tdata;
    logic [DW/8-1:0] axis_in_tkeep;
    logic            axis_in_tlast;
    logic            axis_in_tvalid;
    logic            axis_in_tready;

    logic [15:0]     axis_plen_tdata;
    logic            axis_plen_tvalid;
    logic            axis_plen_tready;

    logic [DW-1:0]   axis_out_tdata;
    logic [DW/8-1:0] axis_out_tkeep;
    logic            axis_out_tlast;
    logic            axis_out_tvalid;
    logic            axis_out_tready;

    logic            length_error;

    modport slave (
        input  axis_in_tdata, axis_in_tkeep, axis_in_tlast, axis_in_tvalid,
        output axis_in_tready,
        input  axis_plen_tdata, axis_plen_tvalid,
        output axis_plen_tready,
        output axis_out_tdata, axis_out_tkeep, axis_out_tlast, axis_out_tvalid,
        input  axis_out_tready,
        output length_error
    );

    modport master (
        output axis_in_tdata, axis_in_tkeep, axis_in_tlast, axis_in_tvalid,
        input  axis_in_tready,
        output axis_plen_tdata, axis_plen_tvalid,
        input  axis_plen_tready,
        input  axis_out_tdata, axis_out_tkeep, axis_out_tlast, axis_out_tvalid,
        output axis_out_tready,
        input  length_error
    );
endinterface

// File: rtl/add_header_post.sv
// Prefixes each packet with one header beat {seq_num, MAGIC, plen}; data beats pass through.
// Optional byte-count check of data against plen: define ADD_HEADER_POST_LENGTH_CHECK_EN.
module add_header_post #(
    parameter int          DW    = 128,   // must match the interface DW
    parameter logic [15:0] MAGIC = 16'hA55A
) (
    input  logic             clk,
    input  logic             reset,
    add_header_post_if.slave io
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_HEADER = 2'd1;
    localparam logic [1:0] S_DATA   = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [15:0] plen_q, plen_d;
    logic [31:0] seq_q, seq_d;
    logic [DW-1:0] hdr;
    logic        beat_acc;

    always_comb begin
        hdr        = '0;
        hdr[15:0]  = plen_q;
        hdr[31:16] = MAGIC;
        hdr[63:32] = seq_q;
    end

    // Reset gates every handshake output so nothing is accepted or offered in the reset cycle.
    always_comb begin
        state_d             = state_q;
        plen_d              = plen_q;
        seq_d               = seq_q;
        io.axis_plen_tready = 1'b0;
        io.axis_in_tready   = 1'b0;
        io.axis_out_tvalid  = 1'b0;
        io.axis_out_tdata   = hdr;
        io.axis_out_tkeep   = '1;
        io.axis_out_tlast   = 1'b0;
        beat_acc            = 1'b0;
        case (state_q)
            S_IDLE: begin
                io.axis_plen_tready = !reset;
                if (io.axis_plen_tvalid) begin
                    plen_d  = io.axis_plen_tdata;
                    state_d = S_HEADER;
                end
            end
            S_HEADER: begin
                io.axis_out_tvalid = !reset;
                if (io.axis_out_tready) begin
                    seq_d   = seq_q + 32'd1;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                io.axis_out_tdata  = io.axis_in_tdata;
                io.axis_out_tkeep  = io.axis_in_tkeep;
                io.axis_out_tlast  = io.axis_in_tlast;
                io.axis_out_tvalid = io.axis_in_tvalid && !reset;
                io.axis_in_tready  = io.axis_out_tready && !reset;
                beat_acc           = io.axis_in_tvalid && io.axis_out_tready;
                if (beat_acc && io.axis_in_tlast) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            plen_q  <= '0;
            seq_q   <= '0;
        end else begin
            state_q <= state_d;
            plen_q  <= plen_d;
            seq_q   <= seq_d;
        end
    end

`ifdef ADD_HEADER_POST_LENGTH_CHECK_EN
    logic [15:0] cnt_q, cnt_d, cnt_sum;
    logic        err_q, err_d;

    function automatic logic [15:0] popcnt(input logic [DW/8-1:0] k);
        popcnt = '0;
        for (int i = 0; i < DW/8; i++) popcnt = popcnt + 16'(k[i]);
    endfunction

    always_comb begin
        cnt_d   = cnt_q;
        err_d   = err_q;
        cnt_sum = cnt_q + popcnt(io.axis_in_tkeep);
        if (state_q == S_HEADER) cnt_d = '0;
        if (beat_acc) begin
            cnt_d = cnt_sum;
            if (io.axis_in_tlast && cnt_sum != plen_q) err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign io.length_error = err_q;
`else
    assign io.length_error = 1'b0;
`endif
endmodule

// File: tb/tb_add_header_post.sv
// Directed bench for add_header_post: header framing, stalls, sequencing, wrap, reset, length flag.
module tb_add_header_post;
    logic clk;
    logic reset;
    int   vecs  = 0;
    int   fails = 0;

    add_header_post_if #(.DW(128)) io ();
    add_header_post #(.DW(128), .MAGIC(16'hA55A)) dut (.clk(clk), .reset(reset), .io(io));

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef ADD_HEADER_POST_LENGTH_CHECK_EN
    localparam logic EXP_LERR = 1'b1;
`else
    localparam logic EXP_LERR = 1'b0;
`endif

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vecs++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] hdr(input logic [15:0] pl, input logic [31:0] sq);
        hdr = {64'h0, sq, 16'hA55A, pl};
    endfunction

    task automatic drv_in(input logic [127:0] d, input logic [15:0] k, input logic l, input logic v);
        io.axis_in_tdata  = d;
        io.axis_in_tkeep  = k;
        io.axis_in_tlast  = l;
        io.axis_in_tvalid = v;
    endtask

    // Single-beat packet, downstream always ready; entered and left at a negedge in IDLE.
    task automatic pkt1(input logic [15:0] pl, input logic [127:0] d, input logic [15:0] k,
                        input logic [31:0] sq);
        io.axis_plen_tvalid = 1'b1;
        io.axis_plen_tdata  = pl;
        io.axis_out_tready  = 1'b1;
        drv_in(d, k, 1'b1, 1'b1);
        #1;
        chk("idle_plen_rdy", io.axis_plen_tready, 1);
        chk("idle_out_vld", io.axis_out_tvalid, 0);
        chk("idle_in_rdy", io.axis_in_tready, 0);
        @(negedge clk);
        io.axis_plen_tvalid = 1'b0;
        #1;
        chk("hdr_vld", io.axis_out_tvalid, 1);
        chk("hdr_data", io.axis_out_tdata, hdr(pl, sq));
        chk("hdr_keep", io.axis_out_tkeep, 16'hFFFF);
        chk("hdr_last", io.axis_out_tlast, 0);
        chk("hdr_in_rdy", io.axis_in_tready, 0);
        chk("hdr_plen_rdy", io.axis_plen_tready, 0);
        @(negedge clk);
        #1;
        chk("dat_data", io.axis_out_tdata, d);
        chk("dat_keep", io.axis_out_tkeep, k);
        chk("dat_last", io.axis_out_tlast, 1);
        chk("dat_in_rdy", io.axis_in_tready, 1);
        chk("dat_plen_rdy", io.axis_plen_tready, 0);
        @(negedge clk);
        io.axis_in_tvalid = 1'b0;
    endtask

    initial begin
        logic [127:0] da, db, dc;
        da = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        db = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
        dc = 128'h0000_0000_0000_0000_CAFE_F00D_1234_5678;

        // Reset with inputs active: every handshake output must be low.
        reset = 1'b1;
        io.axis_plen_tvalid = 1'b1;
        io.axis_plen_tdata  = 16'h0;
        io.axis_out_tready  = 1'b1;
        drv_in(da, 16'hFFFF, 1'b1, 1'b1);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_plen_rdy", io.axis_plen_tready, 0);
        chk("rst_out_vld", io.axis_out_tvalid, 0);
        chk("rst_in_rdy", io.axis_in_tready, 0);
        chk("rst_lerr", io.length_error, 0);
        @(negedge clk);
        reset = 1'b0;

        // plen=16, one full beat.
        pkt1(16'd16, da, 16'hFFFF, 32'd0);
        #1;
        chk("post_idle_vld", io.axis_out_tvalid, 0);

        // plen=40, three beats, downstream ready toggling.
        io.axis_plen_tvalid = 1'b1;
        io.axis_plen_tdata  = 16'd40;
        io.axis_out_tready  = 1'b0;
        #1;
        chk("p40_plen_rdy", io.axis_plen_tready, 1);
        @(negedge clk);
        io.axis_plen_tvalid = 1'b0;
        drv_in(da, 16'hFFFF, 1'b0, 1'b1);
        #1;
        chk("p40_hdr_stall", io.axis_out_tdata, hdr(16'd40, 32'd1));
        chk("p40_hdr_stall_vld", io.axis_out_tvalid, 1);
        @(negedge clk);
        io.axis_out_tready = 1'b1;
        #1;
        chk("p40_hdr_hold", io.axis_out_tdata, hdr(16'd40, 32'd1));
        chk("p40_hdr_in_rdy", io.axis_in_tready, 0);
        @(negedge clk);
        io.axis_out_tready = 1'b0;
        #1;
        chk("p40_b1_data", io.axis_out_tdata, da);
        chk("p40_b1_in_rdy_stall", io.axis_in_tready, 0);
        chk("p40_b1_last", io.axis_out_tlast, 0);
        @(negedge clk);
        io.axis_out_tready = 1'b1;
        #1;
        chk("p40_b1_in_rdy", io.axis_in_tready, 1);
        @(negedge clk);
        drv_in(db, 16'hFFFF, 1'b0, 1'b1);
        io.axis_out_tready = 1'b0;
        #1;
        chk("p40_b2_data", io.axis_out_tdata, db);
        chk("p40_b2_last", io.axis_out_tlast, 0);
        @(negedge clk);
        io.axis_out_tready = 1'b1;
        @(negedge clk);
        drv_in(dc, 16'h00FF, 1'b1, 1'b1);
        io.axis_out_tready = 1'b0;
        #1;
        chk("p40_b3_data", io.axis_out_tdata, dc);
        chk("p40_b3_keep", io.axis_out_tkeep, 16'h00FF);
        chk("p40_b3_last", io.axis_out_tlast, 1);
        @(negedge clk);
        io.axis_out_tready = 1'b1;
        #1;
        chk("p40_b3_in_rdy", io.axis_in_tready, 1);
        @(negedge clk);
        io.axis_in_tvalid = 1'b0;
        #1;
        chk("p40_end_vld", io.axis_out_tvalid, 0);
        chk("p40_lerr", io.length_error, 0);

        // Three back-to-back packets; plen is presented again at each IDLE.
        for (int p = 0; p < 3; p++)
            pkt1(16'd16, da ^ 128'(p), 16'hFFFF, 32'(2 + p));

        // Data valid five cycles before plen: stalled, no output.
        drv_in(db, 16'hFFFF, 1'b1, 1'b1);
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("early_in_rdy", io.axis_in_tready, 0);
            chk("early_out_vld", io.axis_out_tvalid, 0);
            @(negedge clk);
        end
        pkt1(16'd16, db, 16'hFFFF, 32'd5);

        // Sequence number wrap.
        force dut.seq_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.seq_q;
        pkt1(16'd0, dc, 16'h000F, 32'hFFFF_FFFF);
        pkt1(16'd16, da, 16'hFFFF, 32'h0000_0000);

        // Reset in the middle of a four-beat packet.
        io.axis_plen_tvalid = 1'b1;
        io.axis_plen_tdata  = 16'd64;
        drv_in(da, 16'hFFFF, 1'b0, 1'b1);
        @(negedge clk);
        io.axis_plen_tvalid = 1'b0;
        #1;
        chk("mr_hdr", io.axis_out_tdata, hdr(16'd64, 32'd1));
        @(negedge clk);
        #1;
        chk("mr_b1_in_rdy", io.axis_in_tready, 1);
        @(negedge clk);
        reset = 1'b1;
        io.axis_plen_tvalid = 1'b1;
        #1;
        chk("mr_rst_out_vld", io.axis_out_tvalid, 0);
        chk("mr_rst_in_rdy", io.axis_in_tready, 0);
        chk("mr_rst_plen_rdy", io.axis_plen_tready, 0);
        @(negedge clk);
        reset = 1'b0;
        io.axis_plen_tvalid = 1'b0;
        #1;
        chk("mr_idle_out_vld", io.axis_out_tvalid, 0);
        chk("mr_idle_in_rdy", io.axis_in_tready, 0);
        chk("mr_idle_plen_rdy", io.axis_plen_tready, 1);
        io.axis_in_tvalid = 1'b0;
        pkt1(16'd16, db, 16'hFFFF, 32'd0);

        // Length mismatch: plen=32, data carries 16+4 bytes.
        io.axis_plen_tvalid = 1'b1;
        io.axis_plen_tdata  = 16'd32;
        drv_in(da, 16'hFFFF, 1'b0, 1'b1);
        @(negedge clk);
        io.axis_plen_tvalid = 1'b0;
        #1;
        chk("le_hdr", io.axis_out_tdata, hdr(16'd32, 32'd1));
        @(negedge clk);
        #1;
        chk("le_b1_in_rdy", io.axis_in_tready, 1);
        @(negedge clk);
        drv_in(db, 16'h000F, 1'b1, 1'b1);
        #1;
        chk("le_before", io.length_error, 0);
        @(negedge clk);
        io.axis_in_tvalid = 1'b0;
        #1;
        chk("le_set", io.length_error, EXP_LERR);
        @(negedge clk);
        #1;
        chk("le_held", io.length_error, EXP_LERR);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("le_cleared", io.length_error, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end
endmodule
